// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage offer/accept handshake plus the data-memory load response into wb_stage.
// With WB_DEBUG_TRACE_EN defined, the memory stage also supplies the instruction PC.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              m_valid;
  logic              m_ready;
  logic [REG_AW-1:0] m_wa;
  logic              m_we;
  logic [DATA_W-1:0] m_result;
  logic              m_is_load;
  logic [2:0]        m_load_type;
  logic [1:0]        m_addr_lo;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0]       m_pc;
  modport master(output m_valid, m_wa, m_we, m_result, m_is_load, m_load_type, m_addr_lo,
                 dresp_data_ok, dresp_data, m_pc, input m_ready);
  modport slave(input m_valid, m_wa, m_we, m_result, m_is_load, m_load_type, m_addr_lo,
                dresp_data_ok, dresp_data, m_pc, output m_ready);
`else
  modport master(output m_valid, m_wa, m_we, m_result, m_is_load, m_load_type, m_addr_lo,
                 dresp_data_ok, dresp_data, input m_ready);
  modport slave(input m_valid, m_wa, m_we, m_result, m_is_load, m_load_type, m_addr_lo,
                dresp_data_ok, dresp_data, output m_ready);
`endif
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM->WB stage driving the register-file write port, aligning load data and exposing bypass status.
// Defining WB_DEBUG_TRACE_EN adds the held PC and the debug_wb_* trace outputs.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  wb_stage_if.slave         m,
  output logic [REG_AW-1:0] wa3,
  output logic              write_enable,
  output logic [DATA_W-1:0] wd3,
  output logic              fwd_valid,
  output logic              fwd_pending,
  output logic [REG_AW-1:0] fwd_wa
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, COMMIT} state_t;
  state_t            state_q, state_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [2:0]        lt_q, lt_d;
  logic [1:0]        lo_q, lo_d;
  logic              accept;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [DATA_W-1:0] aligned;
  assign m.m_ready = (state_q == IDLE) || (state_q == COMMIT);
  assign accept = m.m_valid && m.m_ready;
  always_comb begin
    b = m.dresp_data[{lo_q, 3'b000} +: 8];
    h = m.dresp_data[{lo_q[1], 4'b0000} +: 16];
    aligned = lt_q == 3'b000 ? {{24{b[7]}}, b} :
              lt_q == 3'b001 ? {{16{h[15]}}, h} :
              lt_q == 3'b100 ? {24'b0, b} :
              lt_q == 3'b101 ? {16'b0, h} : m.dresp_data;
  end
  // Accept only happens in IDLE/COMMIT, so it never races the load-data capture.
  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    we_d    = we_q;
    val_d   = val_q;
    lt_d    = lt_q;
    lo_d    = lo_q;
    if (accept) begin
      wa_d    = m.m_wa;
      we_d    = m.m_we;
      val_d   = m.m_result;
      lt_d    = m.m_load_type;
      lo_d    = m.m_addr_lo;
      state_d = m.m_is_load ? WAIT_DATA : COMMIT;
    end else if (state_q == WAIT_DATA && m.dresp_data_ok) begin
      val_d   = aligned;
      state_d = COMMIT;
    end else if (state_q == COMMIT) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wa_q    <= '0;
      we_q    <= 1'b0;
      val_q   <= '0;
      lt_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      val_q   <= val_d;
      lt_q    <= lt_d;
      lo_q    <= lo_d;
    end
  end
  assign write_enable = (state_q == COMMIT) && we_q && (wa_q != '0);
  assign wa3          = wa_q;
  assign wd3          = val_q;
  assign fwd_valid    = write_enable;
  assign fwd_pending  = (state_q == WAIT_DATA) && we_q && (wa_q != '0);
  assign fwd_wa       = wa_q;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] pc_q, pc_d;
  assign pc_d = accept ? m.m_pc : pc_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pc_q <= '0;
    else pc_q <= pc_d;
  end
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{write_enable}};
  assign debug_wb_rf_wnum  = wa3;
  assign debug_wb_rf_wdata = wd3;
`endif
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM→WB pipeline stage of the MIPS core; sits directly upstream of the register file and drives its write port (wa3/write_enable/wd3).
- Accepts one retiring instruction at a time from the memory stage via a valid/ready handshake.
- For loads: waits for the data-memory response, then byte/halfword-aligns and extends the returned word.
- Exposes the in-flight destination for bypass/hazard logic, because register-file reads return pre-write values.

Parameters:
DATA_W, 32, datapath width; only 32 supported.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
m_valid  in  1  memory stage offers an instruction
m_ready  out  1  stage can accept this cycle
m_wa  in  REG_AW  destination register
m_we  in  1  instruction writes a register
m_result  in  DATA_W  ALU/link result (non-loads)
m_is_load  in  1  instruction is a load
m_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others decode as LW
m_addr_lo  in  2  low bits of the load address
dresp_data_ok  in  1  load data valid this cycle
dresp_data  in  DATA_W  raw 32-bit word from data memory
wa3  out  REG_AW  register-file write address
write_enable  out  1  register-file write strobe
wd3  out  DATA_W  register-file write data
fwd_valid  out  1  held value is final and forwardable
fwd_pending  out  1  held load still awaiting data (consumer must stall on match)
fwd_wa  out  REG_AW  destination of held instruction

Behaviour:
- States: IDLE, WAIT_DATA, COMMIT. Reset (async, resetn=0) → IDLE, all held registers 0; write_enable=0, wa3=0, wd3=0, fwd_*=0.
- m_ready = (state==IDLE) || (state==COMMIT). Combinational; does not depend on m_valid.
- Accept when m_valid && m_ready. On accept, latch m_wa, m_we, m_result, m_is_load, m_load_type, m_addr_lo.
- Next state on accept:
  - m_is_load=0 → COMMIT.
  - m_is_load=1 → WAIT_DATA.
- WAIT_DATA:
  - On dresp_data_ok=1: capture the aligned value, go to COMMIT.
  - Otherwise stay; no timeout.
  - dresp_data_ok is ignored in IDLE and COMMIT.
- COMMIT lasts exactly one cycle:
  - write_enable = held_we && (held_wa != 0); wa3 = held_wa; wd3 = held value.
  - Same cycle: if a new accept occurs, go to the next state per the new instruction (back-to-back, one instruction per cycle for non-loads); else go to IDLE.
- Outside COMMIT: write_enable=0. wa3/wd3 hold their last values (don't-care).
- Latency:
  - Non-load: write_enable is asserted in the cycle after acceptance.
  - Load: write_enable is asserted in the cycle after dresp_data_ok.
- Load alignment:
  - Byte select: m_addr_lo picks byte 0..3 (byte 0 = bits 7:0).
  - Halfword select: m_addr_lo[1] picks the halfword; m_addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through (m_addr_lo ignored).
- Register 0: writes with wa=0 are suppressed and never reported via fwd_valid.
- Forwarding outputs:
  - fwd_wa = held_wa.
  - fwd_pending = (state==WAIT_DATA) && held_we && held_wa!=0.
  - fwd_valid = (state==COMMIT) && write_enable.
- Reset mid-operation (e.g. in WAIT_DATA): immediate return to IDLE; a later dresp_data_ok is ignored.

Optional Feature:
WB_DEBUG_TRACE_EN
- Defined: adds inputs m_pc (32 bits) and outputs debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (5), debug_wb_rf_wdata (32).
  - debug_wb_pc is the held PC; it is valid whenever state==COMMIT.
  - debug_wb_rf_wen = {4{write_enable}}.
  - wnum/wdata mirror wa3/wd3.
  - All reset to 0.
- Undefined: these ports and the PC register do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset release, m_valid=1, non-load wa=5, we=1, result=32'h1234_5678 → next cycle write_enable=1, wa3=5, wd3=32'h1234_5678, fwd_valid=1; m_ready stays 1.
2. Three back-to-back non-loads (wa=1,2,3) on consecutive cycles → three consecutive write_enable pulses carrying wa3=1,2,3 in order; m_ready is never 0.
3. LB with addr_lo=2'b11, wa=8; dresp_data=32'h80AA_BBCC arrives 3 cycles later:
   - During the wait: m_ready=0, fwd_pending=1, fwd_wa=8.
   - Cycle after data_ok: wd3=32'hFFFF_FF80.
   - Repeat as LBU → wd3=32'h0000_0080.
4. LH addr_lo=2'b10 with data 32'h8001_7FFF → wd3=32'hFFFF_8001; LHU addr_lo=2'b00 → 32'h0000_7FFF; LW with addr_lo=2'b01 → full word.
5. Non-load with wa=0, we=1, result=32'hDEAD_BEEF → write_enable=0 and fwd_valid=0 in COMMIT.
6. Load accepted, resetn pulsed low in WAIT_DATA, then dresp_data_ok=1 → all outputs 0, state IDLE, no write.
